// File: rtl/sram_1rw_arbiter.sv
// Shares one single-port (1RW) SRAM macro between pipeline port A and refill/maintenance port B.
// Define SRAM_ARB_INIT_CLEAR_EN to zero the whole array after every reset before requests are accepted.
module sram_1rw_arbiter #(
    parameter int unsigned ADDR_W       = 9,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              resp_valid,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_data,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              init_done
);
    localparam int unsigned        CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]   STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic              in_init;
    logic [ADDR_W-1:0] init_addr;
    logic              grant_a;
    logic              grant_b;
    logic              read_grant;
    logic [CNT_W-1:0]  starve_cnt;

`ifdef SRAM_ARB_INIT_CLEAR_EN
    localparam int unsigned       DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] init_cnt;

    always_ff @(posedge clock) begin
        if (reset) state <= ST_INIT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: if (init_cnt == LAST_ADDR) state_nxt = ST_RUN;
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_INIT;
        endcase
    end

    always_comb begin
        in_init   = (state == ST_INIT);
        init_done = (state == ST_RUN);
        init_addr = init_cnt;
    end

    // Clear walk: one zero-write per cycle while in INIT
    always_ff @(posedge clock) begin
        if (reset)                 init_cnt <= '0;
        else if (state == ST_INIT) init_cnt <= init_cnt + ADDR_W'(1);
    end
`else
    always_comb begin
        in_init   = 1'b0;
        init_done = 1'b1;
        init_addr = '0;
    end
`endif

    // Same-cycle arbitration: A wins contention unless B has waited STARVE_LIMIT cycles
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!reset && !in_init) begin
            if (a_valid && b_valid) begin
                if (starve_cnt == STARVE_MAX) grant_b = 1'b1;
                else                          grant_a = 1'b1;
            end else begin
                grant_a = a_valid;
                grant_b = b_valid;
            end
        end
    end

    always_comb begin
        a_ready    = grant_a;
        b_ready    = grant_b;
        read_grant = (grant_a && !a_we) || (grant_b && !b_we);
        sram_en    = grant_a || grant_b;
        sram_wmode = grant_b ? b_we    : (grant_a && a_we);
        sram_addr  = grant_b ? b_addr  : a_addr;
        sram_wdata = grant_b ? b_wdata : a_wdata;
        if (in_init && !reset) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = init_addr;
            sram_wdata = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)                    starve_cnt <= '0;
        else if (!b_valid || grant_b) starve_cnt <= '0;
        else if (starve_cnt != STARVE_MAX)
                                      starve_cnt <= starve_cnt + CNT_W'(1);
    end

    // Read response tag follows the grant by one cycle, matching macro read latency
    always_ff @(posedge clock) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
        end else begin
            resp_valid <= read_grant;
            if (read_grant) resp_id <= grant_b;
        end
    end

    assign resp_data = sram_rdata;

endmodule

// File: tb/tb_sram_1rw_arbiter.sv
// Self-checking bench for sram_1rw_arbiter: vector table, corner sequences and randomized traffic
// checked against a per-cycle behavioural model of the arbitration and memory contents.
module tb_sram_1rw_arbiter;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STARVE = 4;
    localparam int          DEPTH  = 16;
`ifdef SRAM_ARB_INIT_CLEAR_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic              clock;
    logic              reset;
    logic              a_valid, a_ready, a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              b_valid, b_ready, b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              resp_valid, resp_id;
    logic [DATA_W-1:0] resp_data;
    logic              sram_en, sram_wmode;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;
    logic              init_done;

    sram_1rw_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE)) dut (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
        .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .init_done(init_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural 1RW macro: registered read data, write on enable+wmode
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clock) begin
        if (sram_en) begin
            if (sram_wmode) mem[sram_addr] <= sram_wdata;
            else            sram_rdata     <= mem[sram_addr];
        end
    end

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int                b_wait;
    int                init_ptr;
    logic [DATA_W-1:0] ref_mem [DEPTH];
    bit                ref_ok  [DEPTH];
    bit                exp_rv;
    bit                exp_rid;
    logic [DATA_W-1:0] exp_rd;
    bit                exp_rd_ok;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check every output against the model, advance the model
    task automatic cycle(input logic rst,
                         input logic av, input logic awe, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                         input logic bv, input logic bwe, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd);
        bit                in_init;
        bit                ga, gb;
        bit                een, ewm;
        logic [ADDR_W-1:0] eaddr;
        logic [DATA_W-1:0] ewd;
        logic [ADDR_W-1:0] raddr;
        @(posedge clock);
        #1;
        reset = rst;
        a_valid = av; a_we = awe; a_addr = aa; a_wdata = ad;
        b_valid = bv; b_we = bwe; b_addr = ba; b_wdata = bd;
        #1;
        in_init = INIT_EN && (init_ptr < DEPTH);
        ga = 1'b0;
        gb = 1'b0;
        if (!rst && !in_init) begin
            if (av && bv) begin
                if (b_wait >= STARVE) gb = 1'b1;
                else                  ga = 1'b1;
            end else begin
                ga = av;
                gb = bv;
            end
        end
        if (!rst && in_init) begin
            een = 1'b1; ewm = 1'b1; eaddr = ADDR_W'(init_ptr); ewd = '0;
        end else if (gb) begin
            een = 1'b1; ewm = bwe; eaddr = ba; ewd = bd;
        end else if (ga) begin
            een = 1'b1; ewm = awe; eaddr = aa; ewd = ad;
        end else begin
            een = 1'b0; ewm = 1'b0; eaddr = aa; ewd = ad;
        end
        chk("a_ready", a_ready, ga);
        chk("b_ready", b_ready, gb);
        chk("sram_en", sram_en, een);
        chk("sram_wmode", sram_wmode, ewm);
        chk("sram_addr", sram_addr, eaddr);
        chk("sram_wdata", sram_wdata, ewd);
        chk("init_done", init_done, !in_init);
        chk("resp_valid", resp_valid, exp_rv);
        if (exp_rv) begin
            chk("resp_id", resp_id, exp_rid);
            if (exp_rd_ok) chk("resp_data", resp_data, exp_rd);
        end
        if (rst) begin
            b_wait = 0; exp_rv = 1'b0; exp_rid = 1'b0; init_ptr = 0;
        end else begin
            if (in_init) begin
                ref_mem[init_ptr] = '0;
                ref_ok[init_ptr]  = 1'b1;
                init_ptr++;
            end
            exp_rv = (ga && !awe) || (gb && !bwe);
            if (exp_rv) begin
                raddr     = gb ? ba : aa;
                exp_rid   = gb;
                exp_rd    = ref_mem[raddr];
                exp_rd_ok = ref_ok[raddr];
            end
            if (ga && awe) begin ref_mem[aa] = ad; ref_ok[aa] = 1'b1; end
            if (gb && bwe) begin ref_mem[ba] = bd; ref_ok[ba] = 1'b1; end
            if (!bv || gb)          b_wait = 0;
            else if (b_wait < STARVE) b_wait++;
        end
    endtask

    task automatic idle(input logic rst);
        cycle(rst, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    typedef struct {
        logic              av, awe;
        logic [ADDR_W-1:0] aa;
        logic [DATA_W-1:0] ad;
        logic              bv, bwe;
        logic [ADDR_W-1:0] ba;
        logic [DATA_W-1:0] bd;
        logic              ea, eb;
    } vec_t;

    vec_t tbl [15];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 4'd0, 32'h0,        1'b0, 1'b0, 4'd0, 32'h0,    1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 4'd0, 32'h0,        1'b1, 1'b1, 4'd2, 32'h2222, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 1'b0, 4'd0, 32'h0,    1'b1, 1'b0};
        for (int i = 3; i <= 12; i++)
            tbl[i] = '{1'b1, 1'b0, 4'd1, 32'h0, 1'b1, 1'b0, 4'd2, 32'h0, (i != 7 && i != 12), (i == 7 || i == 12)};
        tbl[13] = '{1'b1, 1'b1, 4'd9, 32'h99,       1'b0, 1'b0, 4'd0, 32'h0,    1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 4'd0, 32'h0,        1'b1, 1'b0, 4'd2, 32'h0,    1'b0, 1'b1};

        for (int i = 0; i < DEPTH; i++) ref_ok[i] = 1'b0;
        b_wait = 0; init_ptr = 0; exp_rv = 1'b0; exp_rid = 1'b0; exp_rd = '0; exp_rd_ok = 1'b0;
        reset = 1'b1;
        a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;

        idle(1'b1);
        idle(1'b1);

`ifdef SRAM_ARB_INIT_CLEAR_EN
        // Walk to init address 9, reset there, then expect a full restart from address 0
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 4'd7, '0, 1'b0, 1'b0, '0, '0);
            if (i == 0) chk("reset_resp_id", resp_id, 1'b0);
        end
        idle(1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 4'd7, '0, 1'b0, 1'b0, '0, '0);
            chk("init_walk_addr", sram_addr, 4'(i));
            chk("init_a_ready", a_ready, 1'b0);
            chk("init_done_low", init_done, 1'b0);
        end
        cycle(1'b0, 1'b1, 1'b0, 4'd7, '0, 1'b0, 1'b0, '0, '0);
        chk("init_done_rise", init_done, 1'b1);
        chk("first_grant", a_ready, 1'b1);
        idle(1'b0);
        chk("init_read_zero", resp_data, 32'h0);
`else
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 4'd0, '0);
        chk("reset_resp_id", resp_id, 1'b0);
        chk("noinit_done", init_done, 1'b1);
        chk("noinit_b_ready", b_ready, 1'b1);
        chk("noinit_sram_en", sram_en, 1'b1);
        idle(1'b0);
`endif

        // Single port write then read
        cycle(1'b0, 1'b1, 1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0);
        cycle(1'b0, 1'b1, 1'b0, 4'd5, '0,           1'b0, 1'b0, '0, '0);
        idle(1'b0);
        chk("single_resp_valid", resp_valid, 1'b1);
        chk("single_resp_id", resp_id, 1'b0);
        chk("single_resp_data", resp_data, 32'hDEADBEEF);

        // Table vectors, including the A,A,A,A,B starvation pattern
        for (int i = 0; i < 15; i++) begin
            cycle(1'b0, tbl[i].av, tbl[i].awe, tbl[i].aa, tbl[i].ad, tbl[i].bv, tbl[i].bwe, tbl[i].ba, tbl[i].bd);
            chk($sformatf("tbl%0d_a_ready", i), a_ready, tbl[i].ea);
            chk($sformatf("tbl%0d_b_ready", i), b_ready, tbl[i].eb);
        end

        // A read then B write of the same address, then B read
        cycle(1'b0, 1'b1, 1'b1, 4'd3, 32'h1111_0003, 1'b0, 1'b0, '0, '0);
        cycle(1'b0, 1'b1, 1'b0, 4'd3, '0,            1'b0, 1'b0, '0, '0);
        cycle(1'b0, 1'b0, 1'b0, '0,   '0,            1'b1, 1'b1, 4'd3, 32'h3333_0003);
        chk("mixed_old_id", resp_id, 1'b0);
        chk("mixed_old_data", resp_data, 32'h1111_0003);
        cycle(1'b0, 1'b0, 1'b0, '0,   '0,            1'b1, 1'b0, 4'd3, '0);
        idle(1'b0);
        chk("mixed_new_valid", resp_valid, 1'b1);
        chk("mixed_new_id", resp_id, 1'b1);
        chk("mixed_new_data", resp_data, 32'h3333_0003);

        // Reset in RUN drops the pending response
        cycle(1'b0, 1'b1, 1'b0, 4'd5, '0, 1'b0, 1'b0, '0, '0);
        cycle(1'b1, 1'b1, 1'b0, 4'd5, '0, 1'b1, 1'b0, 4'd2, '0);
        chk("rst_a_ready", a_ready, 1'b0);
        chk("rst_sram_en", sram_en, 1'b0);
        idle(1'b0);
        chk("rst_drop_resp", resp_valid, 1'b0);

        // Fill every address so randomized reads have known data
        for (int i = 0; i < DEPTH + 16; i++)
            cycle(1'b0, 1'b1, 1'b1, 4'(i), $urandom(), 1'b0, 1'b0, '0, '0);

        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 149) == 0,
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom(),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom());
        end
        idle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sram_1rw_arbiter.md
# sram_1rw_arbiter

Sequencer and arbiter that shares one single-port (1RW) SRAM macro, such as the 512x64 data-array way or the L2 TLB RAM, between two requesters. Port A is the pipeline-side requester. Port B is the refill/maintenance requester. The block grants at most one access per cycle, drives the macro's enable/write-mode/address/data pins, returns read data tagged with the requester ID, and optionally clears the whole array after reset. It sits between the cache/TLB control logic and the `*_ext` SRAM wrapper.

## Interface
Parameters:
- ADDR_W, 9, SRAM address width; DEPTH = 1 << ADDR_W
- DATA_W, 64, SRAM word width
- STARVE_LIMIT, 4, consecutive cycles port B may be blocked before it overrides port A (≥1)

Ports:
- clock  in  1  sole clock; the SRAM clock pin is driven from the same net
- reset  in  1  synchronous, active-high
- a_valid  in  1  port A request
- a_ready  out  1  port A granted this cycle
- a_we  in  1  1 = write, 0 = read
- a_addr  in  ADDR_W  port A address
- a_wdata  in  DATA_W  port A write data
- b_valid, b_ready, b_we, b_addr, b_wdata  as port A, for port B
- resp_valid  out  1  read data valid
- resp_id  out  1  0 = A, 1 = B
- resp_data  out  DATA_W  read data
- sram_en  out  1  macro enable (the wrapper inverts it to csb)
- sram_wmode  out  1  macro write mode (the wrapper inverts it to web)
- sram_addr  out  ADDR_W  macro address
- sram_wdata  out  DATA_W  macro write data
- sram_rdata  in  DATA_W  macro read data, valid the cycle after a read
- init_done  out  1  array ready; requests are accepted only when this is 1

## Operation
- States: INIT (present only with the macro below) and RUN.
- INIT:
  - addr counter walks 0..DEPTH-1, one address per cycle.
  - Each cycle: sram_en=1, sram_wmode=1, sram_wdata=0.
  - a_ready = b_ready = 0 throughout.
  - After writing DEPTH-1, go to RUN and set init_done=1.
- RUN arbitration (combinational, same cycle):
  - If only one port is valid, that port is granted.
  - If both are valid, A is granted unless starve_cnt == STARVE_LIMIT, in which case B is granted.
- Starvation counter:
  - starve_cnt width is $clog2(STARVE_LIMIT+1).
  - Increments each cycle b_valid=1 and b_ready=0; saturates at STARVE_LIMIT.
  - Clears on a B grant or when b_valid=0.
- Grant cycle:
  - sram_en=1; sram_wmode, sram_addr, sram_wdata come from the granted port.
  - With no grant: sram_en=0, sram_wmode=0; addr/wdata hold the A-port values (don't-care).
- Read response:
  - resp_valid and resp_id are registered on a read grant.
  - resp_data = sram_rdata, passed through combinationally.
  - Writes produce no response.
- Requesters may change or withdraw a request in any cycle. There is no hold requirement, because the grant is same-cycle.
- Back-to-back write then read of the same address returns the new data; this is macro behaviour and is not bypassed.

## Timing
- Reset values: a_ready=0, b_ready=0, resp_valid=0, resp_id=0, sram_en=0, sram_wmode=0, starve_cnt=0, init counter=0. init_done=0 with the macro; 1 without it.
- Grant latency is 0 cycles (ready is asserted in the valid cycle). Read latency is 1 cycle (resp_valid in cycle N+1 for a grant in cycle N).
- One access per cycle; sustained throughput is 1 access per cycle.
- INIT lasts exactly DEPTH cycles after reset deasserts (cycles 0..DEPTH-1). init_done rises in cycle DEPTH, and a request can be granted in that same cycle.
- Reset asserted mid-INIT restarts the walk at address 0. Reset asserted in RUN drops any pending response: resp_valid is 0 in the next cycle.

## Configuration
- SRAM_ARB_INIT_CLEAR_EN defined: the INIT state and its address counter exist, and the array is zeroed after every reset.
- SRAM_ARB_INIT_CLEAR_EN undefined: no INIT state, init_done is constant 1, and the block is in RUN from the first cycle after reset. Array contents are undefined until written.

## Test plan
- Init: reset, macro defined, ADDR_W=4 → 16 consecutive zero-writes to addresses 0..15, a_ready/b_ready=0 during them, init_done=1 in cycle 16; a read of address 7 returns 0.
- Single port: A writes 0xDEAD_BEEF to address 5, then A reads address 5 → resp_valid 1 cycle after the read grant, resp_id=0, resp_data=0xDEADBEEF.
- Contention: A and B both valid for 10 cycles with STARVE_LIMIT=4 → grants A,A,A,A,B,A,A,A,A,B (starve_cnt clears after each B grant).
- Mixed: A reads address 3 in cycle N, B writes address 3 in cycle N+1 → the response in N+1 carries the old value with resp_id=0, and a B read in N+2 returns the new value with resp_id=1.
- Reset mid-INIT: assert reset at init address 9 → after release, the walk restarts at address 0 and init_done rises exactly DEPTH cycles later.
- Macro undefined: init_done=1 in the first cycle after reset, and b_valid alone is granted immediately with sram_en=1.
